// File: rtl/npc_pkg.sv
// npc_pkg
//   Types and constants shared across the NPC core.
//   fetch_state_t : fetch sequencer state encoding (IDLE, REQ, WAIT, EXEC, HALT)
//   NPC_RESET_PC  : PC value loaded by the PC register on reset
package npc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        EXEC = 3'd3,
        HALT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Instruction-memory request/response channel of the fetch sequencer.
//   req_valid/req_addr/req_ready : fetch request (sequencer -> memory)
//   rsp_valid/rsp_data/rsp_ready : instruction response (memory -> sequencer)
//   master : sequencer side, slave : memory side
interface fetch_sequencer_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        output rsp_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        input  rsp_ready
    );

endinterface

// File: rtl/fetch_watchdog.sv
// fetch_watchdog
//   Counts WAIT cycles without a response and flags a timeout on the cycle
//   the count would reach TIMEOUT_CYCLES.
//   clk, rst     : clock, synchronous active-high reset
//   i_clear      : request accepted; WAIT starts on the next cycle
//   i_wait       : sequencer is in WAIT
//   i_rsp_valid  : response present this cycle (wins over the timeout)
//   o_timeout    : combinational timeout strobe
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_wait,
    input  logic i_rsp_valid,
    output logic o_timeout
);

    // Count only needs to hold 0..TIMEOUT_CYCLES-1: the limit cycle itself
    // leaves WAIT, so the wrapped value is never observed.
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_wait && !i_rsp_valid) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // r_cnt holds the number of completed empty WAIT cycles, so this cycle
    // is empty cycle number TIMEOUT_CYCLES when r_cnt == LAST.
    assign o_timeout = i_wait && !i_rsp_valid && (r_cnt == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle instruction-fetch controller for the NPC core. Fetches at the
//   current PC, holds the returned instruction for execute, pulses the PC
//   write-enable on completion, owns halt (ebreak) and the retired count.
//   Optional build macro: FETCH_WATCHDOG_EN adds a WAIT timeout that raises
//   o_fetch_err and halts; without it o_fetch_err stays 0.
//
//   clk, rst      : clock, synchronous active-high reset
//   i_pc          : current PC from the PC register
//   bus           : memory request/response channel (master side)
//   o_inst        : registered instruction
//   o_inst_valid  : o_inst is live for execution
//   i_exec_done   : execute of o_inst complete
//   i_halt_req    : o_inst is ebreak
//   o_pc_we       : one-cycle PC update enable
//   o_halted      : sticky halt
//   o_fetch_err   : sticky watchdog error
//   o_instret     : retired-instruction count
//
//   state | meaning
//   IDLE  | post-reset settle cycle, nothing asserted
//   REQ   | request at i_pc presented until accepted
//   WAIT  | request accepted, waiting for the instruction word
//   EXEC  | instruction held for execute until done or halt
//   HALT  | stopped; only rst leaves
module fetch_sequencer
    import npc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_pc,
    fetch_sequencer_if.master    bus,
    output logic [31:0]          o_inst,
    output logic                 o_inst_valid,
    input  logic                 i_exec_done,
    input  logic                 i_halt_req,
    output logic                 o_pc_we,
    output logic                 o_halted,
    output logic                 o_fetch_err,
    output logic [CNT_W-1:0]     o_instret
);

    fetch_state_t     r_state;
    logic             r_req_valid;
    logic             r_rsp_ready;
    logic             r_inst_valid;
    logic             r_halted;
    logic             r_fetch_err;
    logic [31:0]      r_inst;
    logic [CNT_W-1:0] r_instret;

    logic w_accept;
    logic w_retire;
    logic w_timeout;

    assign w_accept = (r_state == REQ) && bus.req_ready;
    // ebreak outranks exec_done: a halting instruction never retires.
    assign w_retire = (r_state == EXEC) && i_exec_done && !i_halt_req;

`ifdef FETCH_WATCHDOG_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_accept),
        .i_wait      (r_state == WAIT),
        .i_rsp_valid (bus.rsp_valid),
        .o_timeout   (w_timeout)
    );
`else
    // No watchdog in this build; the compare is constant false, so WAIT
    // waits indefinitely and the error flag never sets.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_valid  <= 1'b0;
            r_rsp_ready  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_fetch_err  <= 1'b0;
            r_inst       <= '0;
            r_instret    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state     <= REQ;
                    r_req_valid <= 1'b1;
                end
                REQ: begin
                    if (w_accept) begin
                        r_state     <= WAIT;
                        r_req_valid <= 1'b0;
                        r_rsp_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.rsp_valid) begin
                        r_state      <= EXEC;
                        r_inst       <= bus.rsp_data;
                        r_rsp_ready  <= 1'b0;
                        r_inst_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_state     <= HALT;
                        r_rsp_ready <= 1'b0;
                        r_halted    <= 1'b1;
                        r_fetch_err <= 1'b1;
                    end
                end
                EXEC: begin
                    if (i_halt_req) begin
                        r_state      <= HALT;
                        r_inst_valid <= 1'b0;
                        r_halted     <= 1'b1;
                    end else if (w_retire) begin
                        r_state      <= REQ;
                        r_inst_valid <= 1'b0;
                        r_req_valid  <= 1'b1;
                        r_instret    <= r_instret + CNT_W'(1);
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_valid  <= 1'b0;
                    r_rsp_ready  <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    // The address tracks i_pc directly; the PC register only moves on
    // o_pc_we, so it is stable for the whole REQ stall.
    assign bus.req_valid = r_req_valid;
    assign bus.req_addr  = r_req_valid ? i_pc : 32'h0;
    assign bus.rsp_ready = r_rsp_ready;

    // Combinational so the PC register updates on the retiring cycle's edge;
    // masked during reset so an in-flight exec_done cannot leak through.
    assign o_pc_we      = w_retire && !rst;
    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_halted     = r_halted;
    assign o_fetch_err  = r_fetch_err;
    assign o_instret    = r_instret;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller for the NPC core. It sequences the PC register: issues a fetch at the current PC over a valid/ready request channel, captures the returned instruction, holds it for the execute datapath, and pulses the PC write-enable only once execution completes. It sits between the PC register, the instruction memory port and the execute/writeback logic. It also owns halt (ebreak) and the retired-instruction count.

## Interface
- `TIMEOUT_CYCLES`, default 255: watchdog limit in WAIT. Only used with `FETCH_WATCHDOG_EN`.
- `CNT_W`, default 64: width of `instret`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pc` in 32: current PC value from the PC register.
- `req_valid` out 1: fetch request valid.
- `req_addr` out 32: fetch address; equals `pc` whenever `req_valid`.
- `req_ready` in 1: memory accepts the request.
- `rsp_valid` in 1: instruction data valid.
- `rsp_data` in 32: instruction word.
- `rsp_ready` out 1: sequencer accepts the response.
- `inst` out 32: registered instruction to decode/execute.
- `inst_valid` out 1: `inst` is live for execution.
- `exec_done` in 1: execute/memory access of `inst` complete.
- `halt_req` in 1: decoded ebreak for current `inst`.
- `pc_we` out 1: one-cycle PC register update enable.
- `halted` out 1: core stopped (sticky until `rst`).
- `fetch_err` out 1: watchdog fired (sticky).
- `instret` out CNT_W: retired-instruction count.

## Operation
- States are IDLE, REQ, WAIT, EXEC, HALT.
- Reset state is IDLE. All outputs are 0 during reset, including `inst`, `instret` and `halted`.
- IDLE: no outputs asserted. Moves to REQ next cycle unconditionally. This gives the PC register one cycle to settle after reset.
- REQ: `req_valid`=1 and `req_addr`=`pc`. Moves to WAIT when `req_ready`=1. Otherwise it stays, with the address held stable.
- WAIT: `rsp_ready`=1. When `rsp_valid`=1, `inst` <= `rsp_data` and the state moves to EXEC. `rsp_valid` in the same cycle as request acceptance is not legal. The response arrives at the earliest one cycle later.
- EXEC: `inst_valid`=1 and `inst` is held constant.
  - `halt_req`=1 takes priority over `exec_done`: moves to HALT, with no `pc_we` and no `instret` increment.
  - Otherwise, when `exec_done`=1: `pc_we`=1 combinationally in that cycle, `instret` increments, and the state moves to REQ.
- HALT: `halted`=1, all handshake outputs are 0, and it exits only on `rst`.
- `rsp_valid` outside WAIT is ignored, and the data is dropped.
- `rst` in any state forces IDLE on the next edge and abandons any in-flight fetch. The memory side is reset by the same `rst`.
- `instret` wraps modulo 2^CNT_W.

## Timing
- With a zero-wait memory and single-cycle execute, each instruction takes 3 cycles: REQ, then WAIT, then EXEC.
- `pc_we` is high exactly one cycle per retired instruction. The PC register updates on that cycle's closing edge, so the next REQ sees the new `pc`.
- `inst` changes only on the WAIT-to-EXEC edge.
- `halted` and `fetch_err` rise one cycle after the triggering condition.

## Configuration
- `FETCH_WATCHDOG_EN` defined: a counter clears on entry to WAIT and increments on each WAIT cycle without `rsp_valid`.
  - When the count reaches `TIMEOUT_CYCLES`, `fetch_err` <= 1, `halted` <= 1 and the state moves to HALT.
  - A response arriving in the same cycle as the limit wins: the fetch completes and no error is raised.
- `FETCH_WATCHDOG_EN` not defined: no counter is built, `fetch_err` is tied 0, and WAIT waits indefinitely.

## Structure
- Shared package `npc_pkg` holds:
  - the state typedef `fetch_state_t` (IDLE, REQ, WAIT, EXEC, HALT);
  - `NPC_RESET_PC` = 32'h8000_0000, shared with the PC register.
- Sub-module `fetch_watchdog` holds the timeout counter and compare. It is instantiated only under the macro.

## Test plan
- Zero-wait memory with `pc`=0x8000_0000, `req_ready`=1, `rsp_data`=0x0000_0413, and `exec_done` tied 1:
  - after `rst` drops, IDLE occupies cycle 0 and `req_valid` is high in cycle 1;
  - `inst`=0x0000_0413 and `pc_we`=1 in cycle 3;
  - `instret`=1 after that edge.
- Backpressure, `req_ready` low for 3 cycles: `req_valid`=1 with `req_addr` stable for 4 cycles, and no `rsp_ready` until acceptance.
- Slow execute, `exec_done` asserted 5 cycles after EXEC entry: `inst_valid` high for 6 cycles, `inst` constant, and exactly one `pc_we` pulse.
- `halt_req` and `exec_done` high together in EXEC: `halted`=1 on the next cycle, `pc_we` never asserts, `instret` is unchanged, and no further `req_valid`.
- `rst` asserted during WAIT, then a stale `rsp_valid` arrives while in IDLE: outputs are 0, the stale data is not captured, and fetch restarts normally.
- With `FETCH_WATCHDOG_EN` and `TIMEOUT_CYCLES`=8, no response is given: `fetch_err` and `halted` go high after 8 WAIT cycles. A repeat with the response arriving on cycle 8 completes the fetch with no error.
